uart_ddr_wr_ctrl: RTL and testbench

//  Write scheduler between the UART 8-to-256 packer and the DDR3 native app interface.

---
 rtl/uart_ddr_wr_ctrl_if.sv | 28 ++
 rtl/uart_ddr_wr_ctrl.sv | 116 +++++++++++
 tb/tb_uart_ddr_wr_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_ddr_wr_ctrl_if.sv
// Packed-word input and DDR3 native app write channel, bundled for uart_ddr_wr_ctrl.
// slave is the controller side; master is the packer/memory-controller side.
interface uart_ddr_wr_ctrl_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  app_rdy;
  logic                  app_wdf_rdy;
  logic                  app_en;
  logic [2:0]            app_cmd;
  logic [ADDR_W-1:0]     app_addr;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic [DATA_W-1:0]     app_wdf_data;
  logic [DATA_W/8-1:0]   app_wdf_mask;

  modport slave (
    input  in_valid, in_data, app_rdy, app_wdf_rdy,
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
  );

  modport master (
    output in_valid, in_data, app_rdy, app_wdf_rdy,
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
  );
endinterface

// File: rtl/uart_ddr_wr_ctrl.sv
// Queues packed words in a small FIFO and issues one single-beat DDR3 write per word,
// walking a fixed address region that wraps at its end.
module uart_ddr_wr_ctrl #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256,
  parameter int FIFO_AW   = 2,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 8,
  parameter int WR_LEN    = 1024
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 init_calib_complete,
  uart_ddr_wr_ctrl_if.slave    bus,
  output logic                 overflow,
  output logic                 wr_done,
  output logic [15:0]          wr_cnt,
  output logic                 dbg_state
);
  // Valid/ready: a command (app_en/app_rdy) or data beat (app_wdf_wren/app_wdf_rdy)
  // transfers on a rising edge where both are high; valid then drops, and address and
  // data stay stable for as long as their valid is high.

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_CNT  = (FIFO_AW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + (WR_LEN - 1) * ADDR_STEP);

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, retire, push, start;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign retire = (state == WRITE) && (!bus.app_en || bus.app_rdy)
                  && (!bus.app_wdf_wren || bus.app_wdf_rdy);
  // Retiring frees a slot in the same cycle, so a full FIFO can still accept.
  assign push   = bus.in_valid && (!full || retire);
  assign start  = (state == IDLE) && !empty && init_calib_complete;

  assign bus.app_cmd      = 3'b000;
  assign bus.app_wdf_end  = bus.app_wdf_wren;
  assign bus.app_wdf_mask = '0;
  assign dbg_state        = (state == WRITE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = WRITE;
      WRITE:   if (retire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      case ({push, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.in_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.app_en       <= 1'b0;
      bus.app_wdf_wren <= 1'b0;
      bus.app_wdf_data <= '0;
      bus.app_addr     <= BASE;
      wr_done          <= 1'b0;
      wr_cnt           <= '0;
    end else begin
      wr_done <= 1'b0;
      if (start) begin
        bus.app_wdf_data <= mem[rd_ptr];
        bus.app_en       <= 1'b1;
        bus.app_wdf_wren <= 1'b1;
      end else if (state == WRITE) begin
        if (bus.app_rdy)     bus.app_en       <= 1'b0;
        if (bus.app_wdf_rdy) bus.app_wdf_wren <= 1'b0;
      end
      if (retire) begin
        wr_cnt <= wr_cnt + 16'd1;
        if (bus.app_addr == LAST_ADDR) begin
          bus.app_addr <= BASE;
          wr_done      <= 1'b1;
        end else begin
          bus.app_addr <= bus.app_addr + STEP;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_ddr_wr_ctrl.sv
// Directed bench for uart_ddr_wr_ctrl with a 4-word region so the address wrap is reached.
// A negedge monitor records command/data handshakes; drain() scores them against exp_q.
module tb_uart_ddr_wr_ctrl;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        init_calib_complete;
  logic        overflow, wr_done, dbg_state;
  logic [15:0] wr_cnt;

  uart_ddr_wr_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  uart_ddr_wr_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_AW(2),
    .BASE_ADDR(0), .ADDR_STEP(8), .WR_LEN(4)
  ) dut (
    .sys_clk             (sys_clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .bus                 (bus),
    .overflow            (overflow),
    .wr_done             (wr_done),
    .wr_cnt              (wr_cnt),
    .dbg_state           (dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_err    = 0;
  int done_pulses = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [DATA_W-1:0] got_data[$];
  logic [ADDR_W-1:0] model_addr = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: handshakes seen here complete on the following rising edge
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (bus.app_en && bus.app_rdy)             got_addr.push_back(bus.app_addr);
      if (bus.app_wdf_wren && bus.app_wdf_rdy)   got_data.push_back(bus.app_wdf_data);
      if (wr_done)                               done_pulses++;
    end
  end

  // drivers
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d, input bit expect_write);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (expect_write) exp_q.push_back(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.app_en) break;
      tick();
    end
    check(tag, bus.app_en, 1'b1);
  endtask

  // scoreboard: compare recorded writes with expected data and region address sequence
  task automatic drain(input string tag, input int n);
    check({tag, "_ncmd"}, got_addr.size(), n);
    check({tag, "_ndata"}, got_data.size(), n);
    while (got_addr.size() > 0 && got_data.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_addr"}, got_addr.pop_front(), model_addr);
      check({tag, "_data"}, got_data.pop_front(), exp_q.pop_front());
      model_addr = (model_addr == 28'd24) ? 28'd0 : model_addr + 28'd8;
    end
    got_addr.delete();
    got_data.delete();
    exp_q.delete();
  endtask

  function automatic logic [DATA_W-1:0] mk(input int k);
    return {8{32'(32'hC0DE_0000 + k)}};
  endfunction

  bit en_seen;

  initial begin
    init_calib_complete = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.app_rdy     = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    repeat (3) tick();

    // reset state
    check("rst_app_en", bus.app_en, 1'b0);
    check("rst_wren", bus.app_wdf_wren, 1'b0);
    check("rst_wdf_end", bus.app_wdf_end, 1'b0);
    check("rst_addr", bus.app_addr, 28'd0);
    check("rst_wdf_data", bus.app_wdf_data, 256'd0);
    check("rst_cmd", bus.app_cmd, 3'b000);
    check("rst_mask", bus.app_wdf_mask, 32'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_wr_done", wr_done, 1'b0);
    check("rst_wr_cnt", wr_cnt, 16'd0);
    check("rst_state", dbg_state, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: three words, both ready high
    for (int k = 1; k <= 3; k++) push_word(mk(k), 1'b1);
    repeat (12) tick();
    drain("t1", 3);
    check("t1_wr_cnt", wr_cnt, 16'd3);
    check("t1_state_idle", dbg_state, 1'b0);

    // 2: command stalled, data accepted; 4th word of region so it wraps
    bus.app_rdy = 1'b0;
    push_word(mk(4), 1'b1);
    wait_en("t2_en_seen");
    check("t2_wren_first", bus.app_wdf_wren, 1'b1);
    check("t2_wdf_end_first", bus.app_wdf_end, 1'b1);
    check("t2_state_write", dbg_state, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_en_hold", bus.app_en, 1'b1);
      check("t2_addr_stable", bus.app_addr, 28'd24);
      check("t2_wren_dropped", bus.app_wdf_wren, 1'b0);
    end
    bus.app_rdy = 1'b1;
    tick();
    check("t2_en_drop", bus.app_en, 1'b0);
    check("t2_wr_done", wr_done, 1'b1);
    check("t2_addr_wrap", bus.app_addr, 28'd0);
    check("t2_wr_cnt", wr_cnt, 16'd4);
    tick();
    check("t2_wr_done_pulse", wr_done, 1'b0);
    drain("t2", 1);

    // 5: calibration low holds writes off
    init_calib_complete = 1'b0;
    push_word(mk(5), 1'b1);
    push_word(mk(6), 1'b1);
    en_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.app_en) en_seen = 1'b1;
      tick();
    end
    check("t5_no_en", en_seen, 1'b0);
    init_calib_complete = 1'b1;
    repeat (10) tick();
    drain("t5", 2);
    check("t5_done_pulses", done_pulses, 1);

    // 3: both stalled, five pushes -> one dropped
    bus.app_rdy     = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    for (int k = 7; k <= 10; k++) push_word(mk(k), 1'b1);
    check("t3_no_ovf_yet", overflow, 1'b0);
    push_word(mk(11), 1'b0);
    check("t3_overflow", overflow, 1'b1);
    repeat (3) tick();
    check("t3_overflow_sticky", overflow, 1'b1);
    bus.app_rdy     = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    repeat (20) tick();
    drain("t3", 4);
    check("t3_wr_cnt", wr_cnt, 16'd10);
    check("t3_overflow_kept", overflow, 1'b1);
    check("t3_done_pulses", done_pulses, 2);

    // 6: reset in the middle of a stalled write
    bus.app_rdy     = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    push_word(mk(12), 1'b0);
    push_word(mk(13), 1'b0);
    wait_en("t6_en_seen");
    rst_n = 1'b0;
    #1;
    check("t6_en_clear", bus.app_en, 1'b0);
    check("t6_wren_clear", bus.app_wdf_wren, 1'b0);
    check("t6_state_clear", dbg_state, 1'b0);
    check("t6_wr_cnt_clear", wr_cnt, 16'd0);
    check("t6_overflow_clear", overflow, 1'b0);
    check("t6_addr_base", bus.app_addr, 28'd0);
    tick();
    tick();
    rst_n = 1'b1;
    got_addr.delete();
    got_data.delete();
    exp_q.delete();
    model_addr = '0;
    bus.app_rdy     = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    tick();
    push_word(mk(14), 1'b1);
    repeat (10) tick();
    drain("t6", 1);
    check("t6_wr_cnt", wr_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
